hamm_rx_ctrl: RTL and testbench

Sequencing controller for the Hamming(7,4) receive path. Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome in a registered step. It flips the single erroneous bit, if any, and presents the 4-bit corrected nibble downstream on a second valid/ready handshake. It sits between the codeword source (switches or link receiver) and the nibble consumer (display driver), and optionally keeps a corrected-error count.

---
 rtl/hamm_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_hamm_rx_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hamm_rx_ctrl.sv
// Hamming(7,4) receive controller: accept codeword, register syndrome, correct, present nibble.
// Optional saturating corrected-error counter enabled by defining HAMM_ERRCNT_EN.
module hamm_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [2:0] out_syn,
    output logic       out_corr,
    input  logic       clr_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYN,
        ST_FIX,
        ST_OUT
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [6:0] r_code;
    logic [2:0] r_syn;
    logic [3:0] r_data;
    logic [2:0] r_osyn;
    logic       r_corr;
    logic       r_valid;

    logic [2:0] w_syn;
    logic [6:0] w_mask;
    logic [6:0] w_fixed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_SYN;
            ST_SYN:  w_next = ST_FIX;
            ST_FIX:  w_next = ST_OUT;
            ST_OUT:  if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Syndrome {s4,s2,s1}; a nonzero value is the 1-based position of the bad bit.
    always_comb begin
        w_syn[0] = r_code[0] ^ r_code[2] ^ r_code[4] ^ r_code[6];
        w_syn[1] = r_code[1] ^ r_code[2] ^ r_code[5] ^ r_code[6];
        w_syn[2] = r_code[3] ^ r_code[4] ^ r_code[5] ^ r_code[6];
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (r_syn == 3'(i + 1)) w_mask[i] = 1'b1;
        end
        w_fixed = r_code ^ w_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code  <= '0;
            r_syn   <= '0;
            r_data  <= '0;
            r_osyn  <= '0;
            r_corr  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) r_code <= in_code;
                ST_SYN:  r_syn <= w_syn;
                ST_FIX: begin
                    r_data  <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
                    r_osyn  <= r_syn;
                    r_corr  <= (r_syn != '0);
                    r_valid <= 1'b1;
                end
                ST_OUT:  if (out_ready) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Gated by rst so the source sees not-ready while reset is held.
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_syn   = r_osyn;
    assign out_corr  = r_corr;

`ifdef HAMM_ERRCNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (r_state == ST_FIX && r_syn != '0 && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign err_cnt = r_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_cnt;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_hamm_rx_ctrl.sv
// Directed bench for hamm_rx_ctrl; expected err_cnt follows HAMM_ERRCNT_EN.
module tb_hamm_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_syn;
    logic       out_corr;
    logic       clr_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    hamm_rx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_syn   (out_syn),
        .out_corr  (out_corr),
        .clr_cnt   (clr_cnt),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump(input logic c);
`ifdef HAMM_ERRCNT_EN
        if (c && exp_cnt != 255) exp_cnt++;
`endif
    endtask

    task automatic send(input logic [6:0] code, input logic [3:0] d, input logic [2:0] s,
                        input logic c, input logic rdy_early);
        out_ready = rdy_early;
        in_valid  = 1'b1;
        in_code   = code;
        chk("acc_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_code  = '0;
        chk("syn_rdy", in_ready, 0);
        chk("syn_vld", out_valid, 0);
        tick();
        chk("fix_vld", out_valid, 0);
        tick();
        bump(c);
        chk("out_vld", out_valid, 1);
        chk("out_data", out_data, d);
        chk("out_syn", out_syn, s);
        chk("out_corr", out_corr, c);
        chk("err_cnt", err_cnt, exp_cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("cons_vld", out_valid, 0);
        chk("cons_rdy", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        #12;
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_syn", out_syn, 0);
        chk("rst_corr", out_corr, 0);
        chk("rst_cnt", err_cnt, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_rdy", in_ready, 1);

        send(7'b0011110, 4'h3, 3'd0, 1'b0, 1'b0);
        send(7'b0001110, 4'h3, 3'd5, 1'b1, 1'b0);
        send(7'b0011111, 4'h3, 3'd1, 1'b1, 1'b0);
        send(7'b1010010, 4'hA, 3'd0, 1'b0, 1'b1);
        send(7'b0010010, 4'hA, 3'd7, 1'b1, 1'b0);
        send(7'b1010110, 4'hA, 3'd3, 1'b1, 1'b1);
        send(7'b1011010, 4'hA, 3'd4, 1'b1, 1'b0);
        send(7'b1111111, 4'hF, 3'd0, 1'b0, 1'b0);
        send(7'b0000000, 4'h0, 3'd0, 1'b0, 1'b0);
        send(7'b0011101, 4'h2, 3'd3, 1'b1, 1'b0);

        // Backpressure with in_valid held high throughout
        in_valid = 1'b1;
        in_code  = 7'b0001110;
        tick();
        in_code = 7'b1010010;
        tick();
        tick();
        bump(1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", out_valid, 1);
            chk("bp_data", out_data, 4'h3);
            chk("bp_syn", out_syn, 3'd5);
            chk("bp_corr", out_corr, 1);
            chk("bp_rdy", in_ready, 0);
            chk("bp_cnt", err_cnt, exp_cnt);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_cons_vld", out_valid, 0);
        chk("bp_cons_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_acc_rdy", in_ready, 0);
        tick();
        tick();
        chk("bp2_vld", out_valid, 1);
        chk("bp2_data", out_data, 4'hA);
        chk("bp2_syn", out_syn, 3'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp2_cons", out_valid, 0);

        for (int i = 0; i < 260; i++) begin
            send(7'b0001110, 4'h3, 3'd5, 1'b1, 1'b1);
        end
`ifdef HAMM_ERRCNT_EN
        chk("sat_cnt", err_cnt, 255);
`else
        chk("nocnt", err_cnt, 0);
`endif

        // clr_cnt on the same edge as an increment
        in_valid = 1'b1;
        in_code  = 7'b0011111;
        tick();
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_cnt = 0;
        chk("clr_vld", out_valid, 1);
        chk("clr_syn", out_syn, 3'd1);
        chk("clr_cnt", err_cnt, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(7'b0010010, 4'hA, 3'd7, 1'b1, 1'b0);

        // Async reset while in SYN
        in_valid = 1'b1;
        in_code  = 7'b0001110;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_cnt", err_cnt, 0);
        chk("arst_data", out_data, 0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("arst_idle", in_ready, 1);
        send(7'b0001110, 4'h3, 3'd5, 1'b1, 1'b0);
        send(7'b1010010, 4'hA, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
